// File: rtl/fall_tick_scheduler.sv
// Stacker game timing scheduler: free-running pixel/display strobes plus a
// level-paced fall tick sequenced by an IDLE/RUN/PAUSE/DROP state machine.
module fall_tick_scheduler #(
    parameter int unsigned BASE_PERIOD = 25000000,
    parameter int unsigned STEP        = 1500000,
    parameter int unsigned MIN_PERIOD  = 2500000,
    parameter int unsigned DROP_PERIOD = 1000000,
    parameter int unsigned SEG_W       = 17,
    parameter int unsigned PIX_W       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause_req,
    input  logic        drop_req,
    input  logic        game_over,
    input  logic [3:0]  level,
    output logic        fall_tick,
    output logic        seg_tick,
    output logic        pix_en,
    output logic [1:0]  state,
    output logic [31:0] cur_period
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DROP  = 2'b11
    } state_t;

    localparam logic [31:0] BASE_P = 32'(BASE_PERIOD);
    localparam logic [31:0] STEP_P = 32'(STEP);
    localparam logic [31:0] MIN_P  = 32'(MIN_PERIOD);
    localparam logic [31:0] DROP_P = 32'(DROP_PERIOD);

    state_t           state_q;
    state_t           state_d;
    logic [PIX_W-1:0] pix_cnt;
    logic [SEG_W-1:0] seg_cnt;
    logic [31:0]      fall_cnt;
    logic [31:0]      prod;
    logic [31:0]      lvl_period;
    logic [31:0]      eff_period;
    logic             counting;
    logic             terminal;

    assign state = state_q;

    // Level-derived period, floored so high levels never go faster than MIN_PERIOD.
    always_comb begin
        prod       = 32'(level) * STEP_P;
        lvl_period = (prod > BASE_P - MIN_P) ? MIN_P : BASE_P - prod;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!game_over && start) state_d = RUN;
            RUN:   if (game_over)            state_d = IDLE;
                   else if (pause_req)       state_d = PAUSE;
                   else if (drop_req)        state_d = DROP;
            DROP:  if (game_over)            state_d = IDLE;
                   else if (pause_req)       state_d = PAUSE;
                   else if (!drop_req)       state_d = RUN;
            PAUSE: if (game_over)            state_d = IDLE;
                   else if (pause_req)       state_d = RUN;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        counting   = (state_q == RUN) || (state_q == DROP);
        eff_period = (state_q == DROP) ? DROP_P : cur_period;
        terminal   = counting && (fall_cnt == eff_period - 32'd1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pix_cnt    <= '0;
            seg_cnt    <= '0;
            fall_cnt   <= '0;
            pix_en     <= 1'b0;
            seg_tick   <= 1'b0;
            fall_tick  <= 1'b0;
            cur_period <= BASE_P;
        end else begin
            pix_cnt  <= pix_cnt + 1'b1;
            seg_cnt  <= seg_cnt + 1'b1;
            pix_en   <= &pix_cnt;
            seg_tick <= &seg_cnt;

            state_q   <= state_d;
            fall_tick <= 1'b0;
            // A state change beats a coincident terminal count: no tick, count restarts.
            if (state_d != state_q) begin
                fall_cnt <= '0;
                if (state_d == RUN) cur_period <= lvl_period;
            end else if (terminal) begin
                fall_cnt  <= '0;
                fall_tick <= 1'b1;
                if (state_q == RUN) cur_period <= lvl_period;
            end else if (counting) begin
                fall_cnt <= fall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/fall_tick_scheduler.md
Name: fall_tick_scheduler

Overview:
Central timing scheduler for the stacker game. It replaces derived clocks with single-cycle enable strobes on the master clock: display refresh (seg_tick), pixel enable (pix_en) and the gameplay fall tick. The fall tick is sequenced by a run/pause/drop/idle FSM, and its period is computed from the current game level. The block sits between the top level and the game logic, VGA and seven-segment drivers, which all run on clk and qualify their logic with these strobes.

Parameters:
BASE_PERIOD, 25000000, fall period in clk cycles at level 0
STEP, 1500000, period reduction per level
MIN_PERIOD, 2500000, floor for the level-derived period
DROP_PERIOD, 1000000, fall period while fast-drop is active
SEG_W, 17, seg_tick divider width (one strobe every 2^SEG_W cycles)
PIX_W, 2, pix_en divider width (one strobe every 2^PIX_W cycles)

Ports:
clk  in  1  master clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin play from IDLE
pause_req  in  1  one-cycle pulse; toggle RUN/DROP <-> PAUSE
drop_req  in  1  level; fast-drop while high
game_over  in  1  one-cycle pulse; abort to IDLE
level  in  4  current level, 0-15
fall_tick  out  1  one-cycle fall strobe
seg_tick  out  1  one-cycle display-mux strobe
pix_en  out  1  one-cycle pixel enable
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DROP
cur_period  out  32  period currently latched for fall_tick

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all counters=0; fall_tick, seg_tick and pix_en=0; cur_period=BASE_PERIOD.
- Free-running dividers ignore the FSM:
  - pix_cnt (PIX_W bits) increments every cycle; pix_en is registered and high for one cycle each time pix_cnt wraps to 0, i.e. every 2^PIX_W cycles.
  - seg_cnt (SEG_W bits) behaves the same way; seg_tick is high every 2^SEG_W cycles.
  - First pix_en occurs 2^PIX_W cycles after reset release, and the first seg_tick likewise after 2^SEG_W cycles.
- Period function: prod = level*STEP in 32 bits; lvl_period = MIN_PERIOD if prod > BASE_PERIOD-MIN_PERIOD, otherwise BASE_PERIOD-prod. cur_period loads lvl_period on entry to RUN (from IDLE, PAUSE or DROP) and on every fall_tick in RUN. A level change mid-period takes effect only at the next tick.
- fall_cnt (32 bits) is cleared on every state change.
  - In RUN/DROP it increments each cycle. When fall_cnt == eff_period-1, fall_cnt returns to 0 and fall_tick is high for the next cycle.
  - eff_period = cur_period in RUN and DROP_PERIOD in DROP.
  - The first fall_tick comes exactly eff_period cycles after the state-entry edge.
  - In IDLE and PAUSE, fall_cnt holds at 0 and fall_tick=0.
- FSM transitions are evaluated each cycle, with priority game_over > pause_req > drop_req > start:
  - IDLE: start -> RUN. pause_req and drop_req are ignored.
  - RUN: game_over -> IDLE; pause_req -> PAUSE; drop_req=1 -> DROP.
  - DROP: game_over -> IDLE; pause_req -> PAUSE; drop_req=0 -> RUN.
  - PAUSE: game_over -> IDLE; pause_req -> RUN, even if drop_req=1 (DROP is re-entered the following cycle); start is ignored.
- Simultaneous events:
  - If a transition and a terminal count occur in the same cycle, the transition wins: no fall_tick is issued and fall_cnt is cleared.
  - If game_over and start arrive together in IDLE, the state stays IDLE.
- Widths: level*STEP must not overflow 32 bits for the given parameters. eff_period must be >= 1; a value of 1 gives a fall_tick on every cycle.
- Reset mid-operation: immediate return to reset values, with no residual strobe.

Test Plan:
(Simulation overrides: BASE=20, STEP=4, MIN=6, DROP=3, SEG_W=4, PIX_W=2.)
- Reset release, idle for 40 cycles -> pix_en at cycles 4, 8, 12, ...; seg_tick at 16 and 32; fall_tick never asserts; state=00; cur_period=20.
- level=0, start pulse -> state=01; fall_tick at +20, +40, +60 cycles after the start edge, each exactly 1 cycle wide.
- level=3 -> cur_period=8. level=4 -> 20-16=4<6, so 6. level=15 -> 6. Changing level 0->3 at cycle 10 of a period -> that tick stays at 20, then subsequent ticks every 8 cycles.
- In RUN, hold drop_req high for 10 cycles -> state=11; fall_tick at +3, +6, +9; on release, state=01 and the next tick arrives cur_period cycles later.
- pause_req at RUN cycle 7 -> state=10 and no ticks for 50 cycles; pause_req again -> state=01 and the next tick arrives 20 cycles later (count restarts).
- game_over in the same cycle as a terminal count -> no fall_tick, state=00. Asserting rst_n=0 mid-DROP -> all outputs return to reset values immediately.
